cic_comb_decimator: RTL
=======================

CIC_COMB_DECIMATOR -- requirements
Module: cic_comb_decimator

Interface
REQ-001 Parameter WIDTH, default 16: data width of all samples, registers and comb arithmetic.
REQ-002 Parameter N_STAGES, default 3: number of cascaded comb stages; legal range 1..8.
REQ-003 Parameter R, default 8: decimation ratio; legal range 1..256.
REQ-004 Parameter M, default 1: differential delay per comb stage; legal values 1, 2.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  x carries a valid high-rate sample this cycle.
REQ-008 x  input  WIDTH  high-rate sample from the integrator chain (two's-complement, modular).
REQ-009 y  output  WIDTH  low-rate filtered sample, valid when out_valid=1.
REQ-010 out_valid  output  1  single-cycle strobe marking a new y.
REQ-011 settled  output  1  high once the comb delay lines contain no reset zeros (warm-up done).

Function
REQ-012 Decimation counter cnt shall count accepted samples 0..R-1; it shall increment only on cycles with in_valid=1 and wrap from R-1 to 0.
REQ-013 With in_valid=0, cnt, all delay lines and all stage registers shall hold.
REQ-014 Capture edge E0: in_valid=1 and cnt=R-1 at posedge; x shall be registered as decimated sample d0, and stage-0 valid shall be set for one cycle.
REQ-015 With R=1, every in_valid=1 cycle shall be a capture edge.
REQ-016 Comb stage k (1..N_STAGES) shall update only on the edge after stage k-1 valid=1: out_k <= in_k - in_k delayed by M stage-k updates; then delay line shifts in in_k.
REQ-017 Each stage shall have its own M-deep delay line holding previous stage inputs, shifting only on that stage's update.
REQ-018 All subtraction shall be modulo 2^WIDTH (wrap-around intended, no saturation, no overflow flag); this makes integrator overflow cancel.
REQ-019 Latency: y and out_valid shall be visible in the cycle after edge E0+N_STAGES (N_STAGES+1 edges including E0).
REQ-020 out_valid shall be high for exactly one cycle per capture edge; y shall hold its last value while out_valid=0.
REQ-021 Captures on consecutive cycles (R=1) shall be fully pipelined: one out_valid per cycle, no loss.
REQ-022 settled shall go high with the out_valid of the (N_STAGES*M+1)-th output after reset and stay high until reset.
REQ-023 No backpressure: downstream shall accept y whenever out_valid=1.

Reset
REQ-024 rstn=0 shall immediately (asynchronously) clear cnt, d0, all delay lines, all stage registers, all valid bits, y=0, out_valid=0, settled=0.
REQ-025 Reset asserted mid-operation shall discard all in-flight samples; no out_valid shall occur for samples accepted before reset.
REQ-026 After rstn rises, the first capture edge shall be the R-th in_valid=1 cycle.
REQ-027 Reset shall have priority over in_valid on the same edge.

Verification
REQ-028 WIDTH=8, N_STAGES=1, R=4, M=1; x=0,1,2,... one per cycle, in_valid=1 -> y sequence 3,4,4,4,...; out_valid every 4th cycle; settled with second output.
REQ-029 Same stimulus, N_STAGES=2 -> y sequence 3,1,0,0,...; latency 3 edges from capture; settled with third output.
REQ-030 WIDTH=8, N_STAGES=1, R=1: x=252 then 0 (wrapped integrator) -> second y=4 (modular), no saturation.
REQ-031 in_valid toggling 1,0,1,0 with R=4 -> capture only on the 4th accepted sample; cnt holds on in_valid=0 cycles.
REQ-032 Assert rstn=0 one cycle after a capture edge with N_STAGES=3 -> out_valid never pulses for that sample; y=0, settled=0 immediately.
REQ-033 Assertions: out_valid one cycle wide; out_valid count equals floor(accepted/R) since reset; all outputs 0 while rstn=0.

Source files
------------

// File: rtl/cic_comb_decimator_if.sv
// Sample bus for the CIC comb decimator: high-rate samples in, low-rate samples out.
interface cic_comb_decimator_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             settled;

    // Sample source / result sink side
    modport master (
        output in_valid, x,
        input  y, out_valid, settled
    );

    // Decimator side
    modport slave (
        input  in_valid, x,
        output y, out_valid, settled
    );
endinterface

// File: rtl/cic_comb_decimator.sv
// Comb half of a CIC decimator: picks every R-th accepted integrator sample,
// then runs it through N_STAGES modular differentiators of delay M.
module cic_comb_decimator #(
    parameter int WIDTH    = 16,
    parameter int N_STAGES = 3,
    parameter int R        = 8,
    parameter int M        = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    cic_comb_decimator_if.slave  bus
);
    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam int SW = $clog2(N_STAGES * M + 2);

    logic [CW-1:0]                          cnt_q, cnt_d;
    logic                                   cap;
    // stg_q[0] is the decimated sample, stg_q[k] is the output of comb stage k
    logic [N_STAGES:0][WIDTH-1:0]           stg_q;
    logic [N_STAGES:0]                      vld_pipe_q;
    logic [N_STAGES:1][M-1:0][WIDTH-1:0]    dly_q;
    logic [SW-1:0]                          ocnt_q;
    logic                                   settled_q;

    // Capture on the R-th accepted sample; the counter only moves on accepted samples
    always_comb begin
        cap   = bus.in_valid && (cnt_q == CW'(R - 1));
        cnt_d = cnt_q;
        if (bus.in_valid)
            cnt_d = cap ? '0 : cnt_q + CW'(1);
    end

    // Decimation counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Capture register plus comb stages; each stage fires only when its input is valid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stg_q      <= '0;
            vld_pipe_q <= '0;
            dly_q      <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[N_STAGES-1:0], cap};
            if (cap)
                stg_q[0] <= bus.x;
            for (int k = 1; k <= N_STAGES; k++) begin
                if (vld_pipe_q[k-1]) begin
                    // wrap-around subtraction lets integrator overflow cancel
                    stg_q[k]    <= stg_q[k-1] - dly_q[k][M-1];
                    dly_q[k][0] <= stg_q[k-1];
                    for (int j = 1; j < M; j++)
                        dly_q[k][j] <= dly_q[k][j-1];
                end
            end
        end
    end

    // Warm-up tracker: once N_STAGES*M outputs have gone by, no reset zeros remain in the delay lines
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ocnt_q    <= '0;
            settled_q <= 1'b0;
        end else if (vld_pipe_q[N_STAGES-1]) begin
            if (ocnt_q == SW'(N_STAGES * M)) settled_q <= 1'b1;
            else                             ocnt_q    <= ocnt_q + SW'(1);
        end
    end

    assign bus.y         = stg_q[N_STAGES];
    assign bus.out_valid = vld_pipe_q[N_STAGES];
    assign bus.settled   = settled_q;
endmodule
